xor_unit_pipe: RTL and testbench



---
 rtl/xor_unit_pkg.sv | 17 +
 rtl/xor_bcast_n.sv | 15 +
 rtl/xor_unit_pipe.sv | 111 +++++++++++
 tb/tb_xor_unit_pipe.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/xor_unit_pkg.sv
// Shared definitions for the XOR unit: operation encodings and default widths.
// Latency: none (package only).
// Backpressure: not applicable.
package xor_unit_pkg;

  // Operation select carried on in_op.
  typedef enum logic [1:0] {
    OP_BCAST = 2'd0,
    OP_VEC   = 2'd1,
    OP_NEG   = 2'd2,
    OP_ACC   = 2'd3
  } op_e;

  localparam int XOR_WIDTH_DEF = 16;
  localparam int XOR_CNT_W_DEF = 8;

endpackage

// File: rtl/xor_bcast_n.sv
// Broadcast XOR gate array: every bit of a is XORed with the single bit b.
// Latency: combinational.
// Backpressure: none (pure logic).
// Ports: a (WIDTH operand), b (broadcast bit), y (WIDTH result).
module xor_bcast_n #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] a,
  input  logic             b,
  output logic [WIDTH-1:0] y
);

  assign y = a ^ {WIDTH{b}};

endmodule

// File: rtl/xor_unit_pipe.sv
// Pipelined XOR unit: broadcast XOR, vector XOR, conditional negate, XOR-accumulate.
// Latency: 1 cycle from accept to out_valid; one result per cycle when out_ready stays high.
// Backpressure: one-deep output register; in_ready = !out_valid || out_ready.
// Ports: clk/rst_n (sync active-low), in_* operand handshake, acc_clr, out_* result
// handshake with out_zero, acc_q accumulator view, txn_cnt saturating accept count.
// Optional macro XOR_UNIT_PARITY_EN adds out_parity (reduction XOR of the result).
module xor_unit_pipe
  import xor_unit_pkg::*;
#(
  parameter int WIDTH = XOR_WIDTH_DEF,
  parameter int CNT_W = XOR_CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic             in_b,
  input  logic [WIDTH-1:0] in_bv,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_zero,
  output logic [WIDTH-1:0] acc_q,
  output logic [CNT_W-1:0] txn_cnt
`ifdef XOR_UNIT_PARITY_EN
  ,
  output logic             out_parity
`endif
);

  logic             accept;
  logic             acc_accept;
  logic [WIDTH-1:0] bcast_y;
  logic [WIDTH-1:0] inv_a;
  logic [WIDTH-1:0] acc_base;
  logic [WIDTH-1:0] result;

  // Output register frees up in the same cycle it is drained.
  assign in_ready   = !out_valid || out_ready;
  assign accept     = in_valid && in_ready;
  assign acc_accept = accept && (in_op == OP_ACC);

  // Clear takes effect before the XOR so a same-cycle ACC starts from zero.
  assign acc_base = acc_clr ? '0 : acc_q;

  xor_bcast_n #(.WIDTH(WIDTH)) u_bcast (
    .a (in_a),
    .b (in_b),
    .y (bcast_y)
  );

  // Same gate array with b tied high gives ~a for the negate path.
  xor_bcast_n #(.WIDTH(WIDTH)) u_inv (
    .a (in_a),
    .b (1'b1),
    .y (inv_a)
  );

  always_comb begin
    result = bcast_y;
    case (in_op)
      OP_BCAST: result = bcast_y;
      OP_VEC:   result = in_a ^ in_bv;
      // Wraps modulo 2^WIDTH, so the most negative value maps to itself.
      OP_NEG:   result = in_b ? (inv_a + WIDTH'(1)) : in_a;
      OP_ACC:   result = acc_base ^ in_a;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_zero  <= 1'b1;
      acc_q     <= '0;
      txn_cnt   <= '0;
    end else begin
      if (accept) begin
        out_valid <= 1'b1;
        out_data  <= result;
        out_zero  <= (result == '0);
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end

      if (acc_accept) begin
        acc_q <= result;
      end else if (acc_clr) begin
        acc_q <= '0;
      end

      if (accept && (txn_cnt != '1)) begin
        txn_cnt <= txn_cnt + CNT_W'(1);
      end
    end
  end

`ifdef XOR_UNIT_PARITY_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_parity <= 1'b0;
    end else if (accept) begin
      out_parity <= ^result;
    end
  end
`endif

endmodule

// File: tb/tb_xor_unit_pipe.sv
// Randomised + directed bench for xor_unit_pipe with a scoreboard queue and monitor.
// Latency: expects results one cycle after each accept.
// Backpressure: exercises out_ready stalls and checks in_ready against the model.
module tb_xor_unit_pipe;

  localparam int W  = 16;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'd0;
  logic [W-1:0]  in_a = '0;
  logic          in_b = 1'b0;
  logic [W-1:0]  in_bv = '0;
  logic          acc_clr = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_data;
  logic          out_zero;
  logic [W-1:0]  acc_q;
  logic [CW-1:0] txn_cnt;
`ifdef XOR_UNIT_PARITY_EN
  logic          out_parity;
`endif

  xor_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_op     (in_op),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_bv     (in_bv),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero),
    .acc_q     (acc_q),
    .txn_cnt   (txn_cnt)
`ifdef XOR_UNIT_PARITY_EN
    ,
    .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] d;
    logic         z;
    logic         p;
  } exp_t;

  exp_t         exp_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  bit           m_valid = 1'b0;
  logic [W-1:0] m_acc = '0;
  int           m_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour written directly from the operation definitions.
  function automatic logic [W-1:0] ref_op(input logic [1:0] op, input logic [W-1:0] a,
                                          input logic b, input logic [W-1:0] bv,
                                          input logic clr);
    case (op)
      2'd0:    return a ^ (b ? {W{1'b1}} : {W{1'b0}});
      2'd1:    return a ^ bv;
      2'd2:    return b ? W'(0 - int'(a)) : a;
      default: return (clr ? {W{1'b0}} : m_acc) ^ a;
    endcase
  endfunction

  // One clock of stimulus; model predicts accept and next state.
  task automatic step(input logic [1:0] op, input logic [W-1:0] a, input logic b,
                      input logic [W-1:0] bv, input logic clr, input logic vld,
                      input logic ordy);
    logic [W-1:0] r;
    bit           acc;
    exp_t         e;
    @(negedge clk);
    in_op = op; in_a = a; in_b = b; in_bv = bv;
    acc_clr = clr; in_valid = vld; out_ready = ordy;
    #1;
    chk("in_ready", in_ready, 32'(!m_valid || ordy));
    acc = vld && (!m_valid || ordy);
    if (acc) begin
      r = ref_op(op, a, b, bv, clr);
      e.d = r; e.z = (r == 0); e.p = ^r;
      exp_q.push_back(e);
      if (op == 2'd3) m_acc = r;
      else if (clr) m_acc = '0;
      if (m_cnt < (1 << CW) - 1) m_cnt++;
      m_valid = 1'b1;
    end else begin
      if (clr) m_acc = '0;
      if (ordy) m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
    chk("out_valid", out_valid, 32'(m_valid));
    chk("acc_q", acc_q, 32'(m_acc));
    chk("txn_cnt", txn_cnt, 32'(m_cnt));
  endtask

  task automatic step_exp(input string name, input logic [1:0] op, input logic [W-1:0] a,
                          input logic b, input logic [W-1:0] bv, input logic clr,
                          input logic [W-1:0] want);
    step(op, a, b, bv, clr, 1'b1, 1'b1);
    chk(name, out_data, 32'(want));
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; in_a = W'($urandom); in_op = 2'($urandom);
    out_ready = 1'($urandom); acc_clr = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    exp_q.delete();
    m_valid = 1'b0; m_acc = '0; m_cnt = 0;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_zero", out_zero, 1);
    chk("rst_out_data", out_data, 0);
    chk("rst_acc_q", acc_q, 0);
    chk("rst_txn_cnt", txn_cnt, 0);
    chk("rst_in_ready", in_ready, 1);
`ifdef XOR_UNIT_PARITY_EN
    chk("rst_out_parity", out_parity, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  // Monitor: compares the presented result every cycle, pops when consumed.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #4;
      if (rst_n && out_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_result", 1, 0);
        end else begin
          e = exp_q[0];
          chk("out_data", out_data, 32'(e.d));
          chk("out_zero", out_zero, 32'(e.z));
`ifdef XOR_UNIT_PARITY_EN
          chk("out_parity", out_parity, 32'(e.p));
`endif
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    logic [W-1:0] held;
    do_reset(2);

    step_exp("bcast_b1", 2'd0, 16'h00FF, 1'b1, 16'h0, 1'b0, 16'hFF00);
    step_exp("bcast_b0", 2'd0, 16'h00FF, 1'b0, 16'h0, 1'b0, 16'h00FF);
    step_exp("neg_one", 2'd2, 16'h0001, 1'b1, 16'h0, 1'b0, 16'hFFFF);
    step_exp("neg_min", 2'd2, 16'h8000, 1'b1, 16'h0, 1'b0, 16'h8000);
    step_exp("neg_off", 2'd2, 16'h1234, 1'b0, 16'h0, 1'b0, 16'h1234);
    step_exp("neg_zero", 2'd2, 16'h0000, 1'b1, 16'h0, 1'b0, 16'h0000);
    chk("neg_zero_flag", out_zero, 1);
    step_exp("acc_first", 2'd3, 16'h0F0F, 1'b0, 16'h0, 1'b0, 16'h0F0F);
    step_exp("acc_second", 2'd3, 16'h00FF, 1'b0, 16'h0, 1'b0, 16'h0FF0);
    chk("acc_q_value", acc_q, 32'h0FF0);
    step_exp("acc_clr_same", 2'd3, 16'h1111, 1'b0, 16'h0, 1'b1, 16'h1111);

    // Saturation of the 2-bit counter.
    do_reset(2);
    step_exp("vec_parity", 2'd1, 16'h0007, 1'b0, 16'h0, 1'b0, 16'h0007);
`ifdef XOR_UNIT_PARITY_EN
    chk("parity_val", out_parity, 1);
`endif
    for (int i = 0; i < 4; i++) step(2'd1, W'($urandom), 1'b0, W'($urandom), 1'b0, 1'b1, 1'b1);
    chk("txn_sat", txn_cnt, 3);

    // Stall: pending result, downstream blocked with an operand waiting.
    do_reset(2);
    step(2'd0, 16'hA5A5, 1'b1, 16'h0, 1'b0, 1'b1, 1'b0);
    held = out_data;
    chk("stall_first", held, 32'h5A5A);
    for (int i = 0; i < 3; i++) step(2'd1, 16'h1234, 1'b0, 16'h00F0, 1'b0, 1'b1, 1'b0);
    chk("stall_hold", out_data, 32'(held));
    chk("stall_cnt", txn_cnt, 1);
    step(2'd1, 16'h1234, 1'b0, 16'h00F0, 1'b0, 1'b1, 1'b1);
    chk("stall_release", out_data, 32'h12C4);
    step(2'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);

    // Reset with a pending result and acc state.
    step(2'd3, 16'hBEEF, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
    do_reset(1);

    for (int i = 0; i < 2000; i++) begin
      if (i % 600 == 599) do_reset(1 + (i % 2));
      step(2'($urandom), W'($urandom), 1'($urandom), W'($urandom),
           ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0),
           ($urandom_range(0, 3) != 0));
    end

    step(2'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    step(2'd0, 16'h0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
    chk("drain_empty", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
